// File: rtl/isa_types.sv
// Shared ISA-level types for the hart: data width, store widths and RAM owner tags.
package isa_types;

    localparam int XLEN = 32;

    // Access width on the RAM write port; loads reuse it for the alignment check.
    typedef enum logic [1:0] {
        write_byte = 2'd0,
        write_half = 2'd1,
        write_word = 2'd2
    } write_width_t;

    // Which requester owns a RAM slot (or its pending response).
    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_FETCH = 2'd1,
        OWNER_LSU   = 2'd2
    } mem_owner_t;

    // True when an access of the given width cannot be served from one RAM word.
    function automatic logic is_misaligned(input write_width_t width, input logic [1:0] lo);
        case (width)
            write_byte: return 1'b0;
            write_half: return lo[0];
            default:    return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and the LSU.
module rr_arb2
    import isa_types::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_fetch,
    input  logic req_lsu,
    output logic gnt_fetch,
    output logic gnt_lsu
);

    mem_owner_t last_owner;

    // Pick the winner: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        // NOTE: default every output first so no path leaves a value held (no latch).
        gnt_fetch = 1'b0;
        gnt_lsu   = 1'b0;
        if (req_fetch && req_lsu) begin
            if (last_owner == OWNER_FETCH) gnt_lsu   = 1'b1;
            else                           gnt_fetch = 1'b1;
        end else begin
            gnt_fetch = req_fetch;
            gnt_lsu   = req_lsu;
        end
    end

    // Remember the most recent winner; idle cycles leave it unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n)       last_owner <= OWNER_FETCH;
        else if (gnt_fetch) last_owner <= OWNER_FETCH;
        else if (gnt_lsu)   last_owner <= OWNER_LSU;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the shared single-port data RAM: grants one access per
// cycle, rejects accesses the RAM cannot perform, and routes read data back.
module mem_arbiter
    import isa_types::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              fetch_req,
    input  logic [XLEN-1:0]   fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic [XLEN-1:0]   fetch_rdata,

    input  logic              lsu_req,
    input  logic              lsu_wenable,
    input  write_width_t      lsu_wwidth,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic [XLEN-1:0]   lsu_rdata,

    output logic [XLEN-1:0]   mem_addr,
    output write_width_t      mem_wwidth,
    output logic              mem_wenable,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    mem_owner_t resp_owner;
    logic       resp_err;
    logic       win_err;

    rr_arb2 u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_fetch (fetch_req),
        .req_lsu   (lsu_req),
        .gnt_fetch (fetch_gnt),
        .gnt_lsu   (lsu_gnt)
    );

    // Any address bit above the RAM's byte-address space is out of range.
    function automatic logic out_of_range(input logic [XLEN-1:0] addr);
        return (addr >> ADDR_BITS) != '0;
    endfunction

    // Steer the winner onto the RAM port; a rejected access keeps its slot but never writes.
    always_comb begin
        mem_addr    = '0;
        mem_wwidth  = write_word;
        mem_wenable = 1'b0;
        mem_wdata   = '0;
        win_err     = 1'b0;
        if (fetch_gnt) begin
            mem_addr = fetch_addr;
            win_err  = is_misaligned(write_word, fetch_addr[1:0]) || out_of_range(fetch_addr);
        end else if (lsu_gnt) begin
            mem_addr    = lsu_addr;
            mem_wwidth  = lsu_wwidth;
            mem_wdata   = lsu_wdata;
            win_err     = is_misaligned(lsu_wwidth, lsu_addr[1:0]) || out_of_range(lsu_addr);
            // Writes are suppressed while reset is held so the RAM cannot be corrupted.
            mem_wenable = lsu_wenable && !win_err && reset_n;
        end
    end

    // Track who owns the read data coming back from the RAM next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_owner <= OWNER_NONE;
            resp_err   <= 1'b0;
        end else begin
            resp_owner <= fetch_gnt ? OWNER_FETCH : (lsu_gnt ? OWNER_LSU : OWNER_NONE);
            resp_err   <= win_err;
        end
    end

    assign fetch_done  = (resp_owner == OWNER_FETCH);
    assign fetch_err   = fetch_done && resp_err;
    assign fetch_rdata = (fetch_done && !resp_err) ? mem_rdata : '0;

    assign lsu_done    = (resp_owner == OWNER_LSU);
    assign lsu_err     = lsu_done && resp_err;
    assign lsu_rdata   = (lsu_done && !resp_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_mem_arbiter;
    import isa_types::*;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            fetch_req;
    logic [31:0]     fetch_addr;
    logic            fetch_gnt, fetch_done, fetch_err;
    logic [31:0]     fetch_rdata;
    logic            lsu_req, lsu_wenable;
    write_width_t    lsu_wwidth;
    logic [31:0]     lsu_addr, lsu_wdata;
    logic            lsu_gnt, lsu_done, lsu_err;
    logic [31:0]     lsu_rdata;
    logic [31:0]     mem_addr;
    write_width_t    mem_wwidth;
    logic            mem_wenable;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_BITS(10)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err),
        .fetch_rdata (fetch_rdata),
        .lsu_req     (lsu_req),
        .lsu_wenable (lsu_wenable),
        .lsu_wwidth  (lsu_wwidth),
        .lsu_addr    (lsu_addr),
        .lsu_wdata   (lsu_wdata),
        .lsu_gnt     (lsu_gnt),
        .lsu_done    (lsu_done),
        .lsu_err     (lsu_err),
        .lsu_rdata   (lsu_rdata),
        .mem_addr    (mem_addr),
        .mem_wwidth  (mem_wwidth),
        .mem_wenable (mem_wenable),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Behavioural RAM: 256 words, byte-lane writes commit on the edge, registered read.
    logic [31:0] ram [256] = '{default: '0};
    logic [31:0] wr_word;
    logic [7:0]  ram_idx;

    assign ram_idx = mem_addr[9:2];

    always_comb begin
        wr_word = ram[ram_idx];
        case (mem_wwidth)
            write_byte: wr_word[8*mem_addr[1:0] +: 8] = mem_wdata[7:0];
            write_half: wr_word[16*mem_addr[1]  +: 16] = mem_wdata[15:0];
            default:    wr_word = mem_wdata;
        endcase
    end

    always @(posedge clock) begin
        if (mem_wenable) ram[ram_idx] <= wr_word;
        mem_rdata <= mem_wenable ? wr_word : ram[ram_idx];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        lsu_req     = 1'b0;
        lsu_wenable = 1'b0;
        lsu_wwidth  = write_word;
        lsu_addr    = '0;
        lsu_wdata   = '0;
    endtask

    task automatic lsu_drive(input logic we, input write_width_t w,
                             input logic [31:0] a, input logic [31:0] d);
        lsu_req     = 1'b1;
        lsu_wenable = we;
        lsu_wwidth  = w;
        lsu_addr    = a;
        lsu_wdata   = d;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #2;
        check("rst fetch_done", fetch_done, 0);
        check("rst lsu_done", lsu_done, 0);
        check("rst lsu_err", lsu_err, 0);
        check("rst mem_wenable", mem_wenable, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wwidth", 32'(mem_wwidth), 32'(write_word));
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Store word then load it back on the next cycle.
        lsu_drive(1'b1, write_word, 32'h10, 32'h8765_4321);
        #1;
        check("st lsu_gnt", lsu_gnt, 1);
        check("st fetch_gnt", fetch_gnt, 0);
        check("st mem_wenable", mem_wenable, 1);
        check("st mem_addr", mem_addr, 32'h10);
        check("st mem_wdata", mem_wdata, 32'h8765_4321);
        tick();
        check("st lsu_done", lsu_done, 1);
        check("st lsu_err", lsu_err, 0);
        lsu_drive(1'b0, write_word, 32'h10, 32'h0);
        #1;
        check("ld lsu_gnt", lsu_gnt, 1);
        check("ld mem_wenable", mem_wenable, 0);
        tick();
        check("ld lsu_done", lsu_done, 1);
        check("ld lsu_rdata", lsu_rdata, 32'h8765_4321);
        check("ld fetch_done", fetch_done, 0);

        // Halfword store into the upper half, then fetch the whole word.
        lsu_drive(1'b1, write_half, 32'h12, 32'h0000_FEDC);
        #1;
        check("sh lsu_gnt", lsu_gnt, 1);
        check("sh mem_wenable", mem_wenable, 1);
        check("sh mem_wwidth", 32'(mem_wwidth), 32'(write_half));
        tick();
        check("sh lsu_done", lsu_done, 1);
        idle();
        fetch_req  = 1'b1;
        fetch_addr = 32'h10;
        #1;
        check("f fetch_gnt", fetch_gnt, 1);
        check("f mem_wwidth", 32'(mem_wwidth), 32'(write_word));
        check("f mem_wdata", mem_wdata, 0);
        check("f mem_wenable", mem_wenable, 0);
        tick();
        check("f fetch_done", fetch_done, 1);
        check("f fetch_err", fetch_err, 0);
        check("f fetch_rdata", fetch_rdata, 32'hFEDC_4321);
        check("f lsu_done", lsu_done, 0);

        // Misaligned halfword store is granted but must not write.
        idle();
        lsu_drive(1'b1, write_half, 32'h13, 32'h0000_AAAA);
        #1;
        check("mis lsu_gnt", lsu_gnt, 1);
        check("mis mem_wenable", mem_wenable, 0);
        tick();
        check("mis lsu_done", lsu_done, 1);
        check("mis lsu_err", lsu_err, 1);
        check("mis lsu_rdata", lsu_rdata, 0);
        lsu_drive(1'b0, write_word, 32'h10, 32'h0);
        tick();
        check("mis ld lsu_err", lsu_err, 0);
        check("mis ld lsu_rdata", lsu_rdata, 32'hFEDC_4321);

        // Byte store into lane 1 of word 0x14, then load it back.
        lsu_drive(1'b1, write_byte, 32'h15, 32'h0000_0077);
        #1;
        check("sb mem_wenable", mem_wenable, 1);
        tick();
        lsu_drive(1'b0, write_word, 32'h14, 32'h0);
        tick();
        check("sb ld lsu_rdata", lsu_rdata, 32'h0000_7700);

        // Out-of-range byte store: granted, no write, error response.
        lsu_drive(1'b1, write_byte, 32'h401, 32'h0000_0011);
        #1;
        check("oor sb lsu_gnt", lsu_gnt, 1);
        check("oor sb mem_wenable", mem_wenable, 0);
        tick();
        check("oor sb lsu_err", lsu_err, 1);

        // Out-of-range fetches: error with zeroed data even when RAM data is nonzero.
        idle();
        fetch_req  = 1'b1;
        fetch_addr = 32'h400;
        #1;
        check("oor f fetch_gnt", fetch_gnt, 1);
        tick();
        check("oor f fetch_done", fetch_done, 1);
        check("oor f fetch_err", fetch_err, 1);
        check("oor f fetch_rdata", fetch_rdata, 0);
        fetch_addr = 32'h410;
        tick();
        check("oor f2 fetch_err", fetch_err, 1);
        check("oor f2 fetch_rdata", fetch_rdata, 0);

        // Reset during a fetch grant: the response must be dropped, writes blocked.
        fetch_addr = 32'h10;
        #1;
        check("rm fetch_gnt", fetch_gnt, 1);
        #1 reset_n = 1'b0;
        lsu_drive(1'b1, write_word, 32'h20, 32'hDEAD_BEEF);
        #1;
        check("rm fetch_done", fetch_done, 0);
        check("rm lsu_gnt tie", lsu_gnt, 1);
        check("rm mem_wenable", mem_wenable, 0);
        tick();
        check("rm fetch_done edge", fetch_done, 0);
        check("rm lsu_done edge", lsu_done, 0);
        reset_n = 1'b1;

        // Continuous contention from reset: strict L,F,L,F alternation.
        lsu_drive(1'b0, write_word, 32'h14, 32'h0);
        for (int i = 0; i < 4; i++) begin
            logic exp_f;
            exp_f = (i % 2) == 1;
            #1;
            check($sformatf("cont%0d fetch_gnt", i), fetch_gnt, exp_f);
            check($sformatf("cont%0d lsu_gnt", i), lsu_gnt, !exp_f);
            tick();
            check($sformatf("cont%0d fetch_done", i), fetch_done, exp_f);
            check($sformatf("cont%0d lsu_done", i), lsu_done, !exp_f);
            check($sformatf("cont%0d both_done", i), fetch_done & lsu_done, 0);
            if (exp_f) check($sformatf("cont%0d fetch_rdata", i), fetch_rdata, 32'hFEDC_4321);
            else       check($sformatf("cont%0d lsu_rdata", i), lsu_rdata, 32'h0000_7700);
        end
        idle();
        tick();
        check("end fetch_done", fetch_done, 0);
        check("end lsu_done", lsu_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
